// File: rtl/versatile_register_n.sv
// versatile_register_n: N-bit multi-mode register (load, up/down count, shift, rotate, LFSR)
//   clk        rising-edge clock
//   reset      synchronous active-high reset (Q=0, serialout=0, carry=0, parity=0)
//   preset     synchronous preset to all ones
//   en         operation enable, 0 holds Q/serialout and clears carry
//   C          mode: 000 hold, 001 load, 010 up, 011 down, 100 shr, 101 shl, 110 ror, 111 lfsr
//   parin      parallel load data
//   serialin   serial input for shifts
//   Q          register contents
//   serialout  registered bit shifted/rotated out
//   carry      registered one-cycle count wrap pulse
//   zero       combinational Q==0
//   parity     registered ^Q when VREG_PARITY_EN is defined, constant 0 otherwise
module versatile_register_n #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             en,
  input  logic [2:0]       C,
  input  logic [WIDTH-1:0] parin,
  input  logic             serialin,
  output logic [WIDTH-1:0] Q,
  output logic             serialout,
  output logic             carry,
  output logic             zero,
  output logic             parity
);
  logic [WIDTH-1:0] r_q, w_q_op;
  logic r_so, r_cy, w_so_op, w_cy_op, w_fb;
  assign w_fb = ^(r_q & TAPS);
  always_comb begin
    w_q_op = r_q;
    w_so_op = r_so;
    w_cy_op = 1'b0;
    if (en) begin
      case (C)
        3'b001: w_q_op = parin;
        3'b010: begin
          w_q_op = r_q + WIDTH'(1);
          w_cy_op = &r_q;
        end
        3'b011: begin
          w_q_op = r_q - WIDTH'(1);
          w_cy_op = ~|r_q;
        end
        3'b100: begin
          w_q_op = {serialin, r_q[WIDTH-1:1]};
          w_so_op = r_q[0];
        end
        3'b101: begin
          w_q_op = {r_q[WIDTH-2:0], serialin};
          w_so_op = r_q[WIDTH-1];
        end
        3'b110: begin
          w_q_op = {r_q[0], r_q[WIDTH-1:1]};
          w_so_op = r_q[0];
        end
        3'b111: begin
          // an all-zero LFSR would lock up, so reseed instead of shifting
          w_q_op = ~|r_q ? LFSR_SEED : {r_q[WIDTH-2:0], w_fb};
          w_so_op = ~|r_q ? 1'b0 : r_q[WIDTH-1];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      r_so <= 1'b0;
      r_cy <= 1'b0;
    end else if (preset) begin
      r_q <= '1;
      r_so <= 1'b0;
      r_cy <= 1'b0;
    end else begin
      r_q <= w_q_op;
      r_so <= w_so_op;
      r_cy <= w_cy_op;
    end
  end
`ifdef VREG_PARITY_EN
  logic r_par;
  logic [WIDTH-1:0] w_q_d;
  assign w_q_d = preset ? '1 : w_q_op;
  always_ff @(posedge clk) begin
    if (reset) r_par <= 1'b0;
    else r_par <= ^w_q_d;
  end
  assign parity = r_par;
`else
  assign parity = 1'b0;
`endif
  assign Q = r_q;
  assign serialout = r_so;
  assign carry = r_cy;
  assign zero = ~|r_q;
endmodule

// File: tb/tb_versatile_register_n.sv
// tb_versatile_register_n: table-driven scoreboard bench for versatile_register_n
module tb_versatile_register_n;
  logic clk = 1'b0;
  logic reset, preset, en, serialin, serialout, carry, zero, parity;
  logic [2:0] C;
  logic [7:0] parin, Q;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic rst, pre, en;
    logic [2:0] c;
    logic [7:0] par;
    logic si;
    logic [7:0] q;
    logic so, cy;
  } vec_t;
  typedef struct {
    logic [7:0] q;
    logic so, cy;
  } exp_t;
  vec_t vt[$];
  exp_t sb[$];
  versatile_register_n #(.WIDTH(8), .TAPS(8'hB8), .LFSR_SEED(8'h01)) dut (
    .clk(clk), .reset(reset), .preset(preset), .en(en), .C(C), .parin(parin),
    .serialin(serialin), .Q(Q), .serialout(serialout), .carry(carry), .zero(zero), .parity(parity)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    logic exp_par;
    reset = v.rst;
    preset = v.pre;
    en = v.en;
    C = v.c;
    parin = v.par;
    serialin = v.si;
    sb.push_back('{v.q, v.so, v.cy});
    @(posedge clk);
    #1;
    e = sb.pop_front();
`ifdef VREG_PARITY_EN
    exp_par = ^e.q;
`else
    exp_par = 1'b0;
`endif
    chk("q", idx, 32'(Q), 32'(e.q));
    chk("serialout", idx, 32'(serialout), 32'(e.so));
    chk("carry", idx, 32'(carry), 32'(e.cy));
    chk("zero", idx, 32'(zero), 32'(e.q == 8'h00));
    chk("parity", idx, 32'(parity), 32'(exp_par));
  endtask
  function automatic logic [7:0] lfsr_model(input logic [7:0] q);
    return q == 8'h00 ? 8'h01 : {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction
  initial begin
    logic [7:0] mq;
    int early;
    reset = 1'b0; preset = 1'b0; en = 1'b0; C = 3'b000; parin = 8'h00; serialin = 1'b0;
    //               rst pre en  C       parin  si  q      so cy
    vt.push_back('{1, 0, 0, 3'b000, 8'h00, 0, 8'h00, 0, 0});
    vt.push_back('{0, 1, 0, 3'b000, 8'h00, 0, 8'hFF, 0, 0});
    vt.push_back('{0, 0, 1, 3'b010, 8'h00, 0, 8'h00, 0, 1});
    vt.push_back('{0, 0, 1, 3'b010, 8'h00, 0, 8'h01, 0, 0});
    vt.push_back('{0, 0, 1, 3'b001, 8'h00, 0, 8'h00, 0, 0});
    vt.push_back('{0, 0, 1, 3'b011, 8'h00, 0, 8'hFF, 0, 1});
    vt.push_back('{0, 0, 1, 3'b001, 8'hA5, 0, 8'hA5, 0, 0});
    vt.push_back('{0, 0, 1, 3'b100, 8'h00, 1, 8'hD2, 1, 0});
    vt.push_back('{0, 0, 1, 3'b110, 8'h00, 0, 8'h69, 0, 0});
    vt.push_back('{0, 0, 1, 3'b001, 8'h00, 0, 8'h00, 0, 0});
    vt.push_back('{0, 0, 1, 3'b111, 8'h00, 0, 8'h01, 0, 0});
    vt.push_back('{0, 0, 1, 3'b111, 8'h00, 0, 8'h02, 0, 0});
    vt.push_back('{0, 0, 1, 3'b101, 8'h00, 1, 8'h05, 0, 0});
    vt.push_back('{0, 0, 1, 3'b001, 8'h80, 0, 8'h80, 0, 0});
    vt.push_back('{0, 0, 1, 3'b101, 8'h00, 0, 8'h00, 1, 0});
    vt.push_back('{0, 0, 1, 3'b000, 8'h00, 0, 8'h00, 1, 0});
    vt.push_back('{0, 0, 1, 3'b011, 8'h00, 0, 8'hFF, 1, 1});
    vt.push_back('{0, 0, 0, 3'b010, 8'h00, 0, 8'hFF, 1, 0});
    vt.push_back('{0, 0, 0, 3'b010, 8'h00, 0, 8'hFF, 1, 0});
    vt.push_back('{0, 0, 0, 3'b010, 8'h00, 0, 8'hFF, 1, 0});
    vt.push_back('{0, 0, 1, 3'b010, 8'h00, 0, 8'h00, 1, 1});
    vt.push_back('{1, 1, 1, 3'b010, 8'h00, 0, 8'h00, 0, 0});
    vt.push_back('{0, 0, 1, 3'b010, 8'h00, 0, 8'h01, 0, 0});
    vt.push_back('{1, 0, 1, 3'b010, 8'h00, 0, 8'h00, 0, 0});
    vt.push_back('{0, 0, 1, 3'b001, 8'h07, 0, 8'h07, 0, 0});
    vt.push_back('{0, 0, 1, 3'b001, 8'h03, 0, 8'h03, 0, 0});
    vt.push_back('{0, 0, 1, 3'b110, 8'h00, 0, 8'h81, 1, 0});
    vt.push_back('{0, 0, 1, 3'b111, 8'h00, 0, 8'h03, 1, 0});
    vt.push_back('{0, 1, 1, 3'b111, 8'h00, 0, 8'hFF, 0, 0});
    vt.push_back('{0, 0, 1, 3'b111, 8'h00, 0, 8'hFE, 1, 0});
    @(negedge clk);
    foreach (vt[i]) step(vt[i], i);
    step('{0, 0, 1, 3'b001, 8'h01, 0, 8'h01, 1, 0}, 100);
    mq = 8'h01;
    early = 0;
    for (int k = 1; k <= 255; k++) begin
      logic so_e;
      so_e = mq[7];
      mq = lfsr_model(mq);
      if (k < 255 && mq == 8'h01) early++;
      step('{0, 0, 1, 3'b111, 8'h00, 0, mq, so_e, 0}, 100 + k);
    end
    chk("lfsr_early_return", 400, 32'(early), 32'd0);
    chk("lfsr_period_q", 401, 32'(Q), 32'h01);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
